color_framebuffer: RTL and testbench
====================================

# color_framebuffer

Dual-port frame buffer of colour indices sitting directly upstream of the index-to-RGB converter. Drawing logic writes `COLOR_WIDTH`-bit indices at (x, y) through a ready/enable write port. The display scan side reads one index per cycle with fixed 2-cycle latency and feeds the converter. The block guarantees the scan output is never `COLOR_NONE`, and it optionally provides a hardware clear-to-black sequencer.

## Interface
- `WIDTH`, 160, buffer width in pixels
- `HEIGHT`, 120, buffer height in pixels
- `X_BITS`, 8, width of x coordinates
- `Y_BITS`, 7, width of y coordinates
- Derived (localparam): `DEPTH = WIDTH*HEIGHT`, `ADDR_BITS = $clog2(DEPTH)`
- `clk` in 1: the single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: write request, qualified by `wr_ready`.
- `wr_x` in `X_BITS`, `wr_y` in `Y_BITS`: write coordinate.
- `wr_color` in `COLOR_WIDTH`: index to store.
- `wr_ready` out 1: write port accepts this cycle.
- `rd_en` in 1: scan read request.
- `rd_x` in `X_BITS`, `rd_y` in `Y_BITS`: read coordinate.
- `rd_index` out `COLOR_WIDTH`: pixel index, never `COLOR_NONE`.
- `rd_valid` out 1: `rd_index` corresponds to the request issued 2 cycles earlier.
- `clear_req` in 1: start clear (only with the clear feature).
- `busy` out 1: clear in progress.
- `clear_done` out 1: one-cycle pulse when a clear finishes.

## Operation
- Storage: `DEPTH` × `COLOR_WIDTH` array. Address = `y*WIDTH + x`, computed at `ADDR_BITS` width. Power-up contents are initialised to `COLOR_BLACK`. `reset` does not alter the contents.
- Write is accepted when `wr_en && wr_ready`. The write is dropped silently when any of the following holds: `wr_x >= WIDTH`, `wr_y >= HEIGHT`, or `wr_color == COLOR_NONE`. `COLOR_NONE` acts as transparent.
- Read stage 1 registers the address and an in-range flag. Read stage 2 registers the memory output. When the request was out of range, `rd_index` is `COLOR_BLACK`. `rd_valid` is `rd_en` delayed by 2 cycles.
- Same address written and read in the same cycle: the read returns the old data (read-before-write).
- Clear FSM states:
  - IDLE: `busy=0`, `wr_ready=1`.
  - CLEAR: a counter walks address 0..`DEPTH-1`, writing `COLOR_BLACK` one address per cycle. `busy=1` and `wr_ready=0`.
  - IDLE→CLEAR on `clear_req`.
  - CLEAR→IDLE after address `DEPTH-1` is written. `clear_done` pulses on the first IDLE cycle and the counter wraps to 0.
- `clear_req` while in CLEAR is ignored; it does not restart the sequence.
- Reads stay fully functional during CLEAR and return whatever is stored at that moment.
- Reset mid-clear: the FSM returns to IDLE and the counter to 0. A partially cleared buffer is left as-is.

## Timing
- Reset values: `rd_valid=0`, `rd_index=COLOR_BLACK`, `busy=0`, `clear_done=0`, `wr_ready=1`. The read pipeline flushes on reset.
- Write latency: data is visible to a read issued on the cycle after acceptance.
- Read latency: exactly 2 cycles, with throughput of one read per cycle and no stalls.
- Clear duration: `DEPTH` cycles of `busy=1`, starting the cycle after `clear_req`. `clear_done` asserts at cycle `DEPTH+1` after `clear_req`.
- `wr_ready` is a registered function of the FSM state and does not depend on `wr_en` combinationally.

## Configuration
- Macro: `COLOR_FB_CLEAR_EN`.
- Defined: the clear FSM and its counter are built, and `clear_req`, `busy` and `clear_done` behave as described above.
- Undefined: the clear FSM and counter are not built, `clear_req` is ignored, `busy` and `clear_done` are tied to 0, and `wr_ready` is tied to 1.

## Test plan
- Write/read: write `COLOR_RED` at (5,3), then read (5,3) on the next cycle → `rd_valid=1` and `rd_index=COLOR_RED` exactly 2 cycles after the read.
- Transparency and range: write `COLOR_NONE` at (5,3), then write `COLOR_BLUE` at (160,0) → reading (5,3) still returns `COLOR_RED`; reading (160,0) returns `COLOR_BLACK`.
- Collision: in one cycle, write `COLOR_GREEN` at (0,0) and read (0,0) → the old value `COLOR_BLACK`. The next read of (0,0) returns `COLOR_GREEN`.
- Clear (`COLOR_FB_CLEAR_EN`): fill several pixels, pulse `clear_req` → `busy` high for 19200 cycles with `wr_ready=0` and writes dropped; a second `clear_req` mid-sequence has no effect; one-cycle `clear_done`; all reads then return `COLOR_BLACK`.
- Reset mid-clear: assert `reset` 100 cycles into a clear → the next cycle shows `busy=0`, `rd_valid=0`, `wr_ready=1`; address 150 retains its pre-clear value.
- Streaming: issue back-to-back reads of x=0..159 on row 2 → 160 consecutive `rd_valid` cycles in order, with no `COLOR_NONE` on `rd_index`.

Source files
------------

// File: rtl/color_framebuffer.sv
// Dual-port colour-index frame buffer: gated write port, 2-cycle scan read port,
// and an optional clear-to-black sequencer built only when COLOR_FB_CLEAR_EN is defined.
module color_framebuffer #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOR_WIDTH = 4,
  parameter logic [COLOR_WIDTH-1:0] COLOR_BLACK = '0,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE  = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [X_BITS-1:0]      wr_x,
  input  logic [Y_BITS-1:0]      wr_y,
  input  logic [COLOR_WIDTH-1:0] wr_color,
  output logic                   wr_ready,
  input  logic                   rd_en,
  input  logic [X_BITS-1:0]      rd_x,
  input  logic [Y_BITS-1:0]      rd_y,
  output logic [COLOR_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   clear_done,
  output logic                   dbg_state
);

  localparam int DEPTH     = WIDTH * HEIGHT;
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(WIDTH);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(HEIGHT);

  function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [X_BITS-1:0] x,
                                                    input logic [Y_BITS-1:0] y);
    return ADDR_BITS'(y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(x);
  endfunction

  logic [COLOR_WIDTH-1:0] r_mem [DEPTH] = '{default: COLOR_BLACK};
  logic [COLOR_WIDTH-1:0] r_mem_q;
  logic                   r_s1_valid;
  logic                   r_s1_in_range;
  logic [COLOR_WIDTH-1:0] r_rd_index;
  logic                   r_rd_valid;

  logic                   w_wr_in_range;
  logic                   w_rd_in_range;
  logic [ADDR_BITS-1:0]   w_wr_addr;
  logic [ADDR_BITS-1:0]   w_rd_addr;
  logic                   w_wr_ok;
  logic                   w_wr_ready;
  logic                   w_clr_we;
  logic [ADDR_BITS-1:0]   w_clr_addr;

  assign w_wr_in_range = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
  assign w_rd_in_range = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
  assign w_wr_addr     = pix_addr(wr_x, wr_y);
  // Out-of-range reads are pointed at address 0 and masked to black at stage 2.
  assign w_rd_addr     = w_rd_in_range ? pix_addr(rd_x, rd_y) : '0;
  assign w_wr_ok       = wr_en && w_wr_ready && w_wr_in_range &&
                         (wr_color != COLOR_NONE) && !reset;

`ifdef COLOR_FB_CLEAR_EN
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDR_BITS-1:0] r_clr_addr;
  logic                 r_wr_ready;
  logic                 r_clear_done;
  logic                 w_busy;
  logic                 w_clr_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_clr_addr   <= '0;
      r_wr_ready   <= 1'b1;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wr_ready   <= (w_next_state == S_IDLE);
      r_clear_done <= (r_state == S_CLEAR) && (w_next_state == S_IDLE);
      if (w_clr_active)
        r_clr_addr <= (r_clr_addr == LAST_ADDR) ? '0 : r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (clear_req) w_next_state = S_CLEAR;
      S_CLEAR: if (r_clr_addr == LAST_ADDR) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = 1'b0;
    w_clr_active = 1'b0;
    if (r_state == S_CLEAR) begin
      w_busy       = 1'b1;
      w_clr_active = 1'b1;
    end
  end

  // A reset cycle must not touch memory, so the sweep write is gated here.
  assign w_clr_we   = w_clr_active && !reset;
  assign w_clr_addr = r_clr_addr;
  assign w_wr_ready = r_wr_ready;
  assign busy       = w_busy;
  assign clear_done = r_clear_done;
  assign dbg_state  = r_state;
`else
  logic w_unused_clear_req;
  assign w_unused_clear_req = clear_req;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
  assign w_wr_ready = 1'b1;
  assign busy       = 1'b0;
  assign clear_done = 1'b0;
  assign dbg_state  = 1'b0;
`endif

  assign wr_ready = w_wr_ready;

  // Memory read sits on the same edge as the write, giving read-before-write.
  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_mem[w_clr_addr] <= COLOR_BLACK;
    else if (w_wr_ok)
      r_mem[w_wr_addr] <= wr_color;
    r_mem_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_in_range <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_index    <= COLOR_BLACK;
    end else begin
      r_s1_valid    <= rd_en;
      r_s1_in_range <= w_rd_in_range;
      r_rd_valid    <= r_s1_valid;
      r_rd_index    <= (r_s1_in_range && (r_mem_q != COLOR_NONE)) ? r_mem_q : COLOR_BLACK;
    end
  end

  assign rd_index = r_rd_index;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_color_framebuffer.sv
// Bench for color_framebuffer: vector table plus directed sequences, with a read
// scoreboard fed at issue time; clear sequences run when COLOR_FB_CLEAR_EN is defined.
module tb_color_framebuffer;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int CW     = 4;
  localparam logic [CW-1:0] BLACK = 4'h0;
  localparam logic [CW-1:0] RED   = 4'h1;
  localparam logic [CW-1:0] GREEN = 4'h2;
  localparam logic [CW-1:0] BLUE  = 4'h3;
  localparam logic [CW-1:0] NONE  = 4'hF;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_x;
  logic [6:0]    wr_y;
  logic [CW-1:0] wr_color;
  logic          wr_ready;
  logic          rd_en;
  logic [7:0]    rd_x;
  logic [6:0]    rd_y;
  logic [CW-1:0] rd_index;
  logic          rd_valid;
  logic          clear_req;
  logic          busy;
  logic          clear_done;
  logic          dbg_state;

  color_framebuffer dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_index(rd_index), .rd_valid(rd_valid),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done), .dbg_state(dbg_state)
  );

  // reference model and scoreboard
  logic [CW-1:0] model [DEPTH];
  logic [CW-1:0] exp_q [$];
  int   n_chk = 0;
  int   n_err = 0;
  logic pipe1, pipe2;
  logic m_busy;
  int   m_cnt;
  logic exp_done;
  logic tbl_use;
  logic [CW-1:0] tbl_exp;
  int   busy_cycles;
  int   done_cycles;
  int   valid_cycles;

  typedef struct {
    logic          wr;
    int            wx;
    int            wy;
    logic [CW-1:0] wc;
    int            rx;
    int            ry;
    logic [CW-1:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] model_read(input int x, input int y);
    if (x < WIDTH && y < HEIGHT) return model[y*WIDTH + x];
    return BLACK;
  endfunction

  // One clock cycle: update the model from the inputs now applied, then check outputs.
  task automatic step();
    logic exp_ready;
    logic [CW-1:0] e;
    exp_ready = !m_busy;
    exp_done  = 1'b0;
    if (reset) begin
      pipe1 = 1'b0;
      pipe2 = 1'b0;
      exp_q.delete();
      m_busy = 1'b0;
      m_cnt  = 0;
    end else begin
      pipe2 = pipe1;
      pipe1 = rd_en;
      if (rd_en) exp_q.push_back(tbl_use ? tbl_exp : model_read(int'(rd_x), int'(rd_y)));
      if (wr_en && exp_ready && int'(wr_x) < WIDTH && int'(wr_y) < HEIGHT && wr_color != NONE)
        model[int'(wr_y)*WIDTH + int'(wr_x)] = wr_color;
`ifdef COLOR_FB_CLEAR_EN
      if (m_busy) begin
        model[m_cnt] = BLACK;
        if (m_cnt == DEPTH-1) begin
          m_busy   = 1'b0;
          m_cnt    = 0;
          exp_done = 1'b1;
        end else begin
          m_cnt++;
        end
      end else if (clear_req) begin
        m_busy = 1'b1;
      end
`endif
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, pipe2});
    if (pipe2) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_index", {28'b0, rd_index}, {28'b0, e});
      end else begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end
    end
    chk("rd_not_none", {31'b0, rd_index == NONE}, 32'd0);
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, !m_busy});
    chk("clear_done", {31'b0, clear_done}, {31'b0, exp_done});
    if (busy) busy_cycles++;
    if (clear_done) done_cycles++;
    if (rd_valid) valid_cycles++;
  endtask

  // driver tasks
  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic do_write(input int x, input int y, input logic [CW-1:0] c);
    wr_en = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_color = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read_exp(input int x, input int y, input logic [CW-1:0] e);
    rd_en = 1'b1; rd_x = 8'(x); rd_y = 7'(y);
    tbl_use = 1'b1; tbl_exp = e;
    step();
    rd_en = 1'b0; tbl_use = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = BLACK;
    pipe1 = 1'b0; pipe2 = 1'b0; m_busy = 1'b0; m_cnt = 0; exp_done = 1'b0;
    tbl_use = 1'b0; tbl_exp = BLACK;
    busy_cycles = 0; done_cycles = 0; valid_cycles = 0;
    wr_x = '0; wr_y = '0; wr_color = BLACK; rd_x = '0; rd_y = '0;
    idle_inputs();

    tbl[0] = '{1'b1,   5,   3, RED,     5,   3, RED};
    tbl[1] = '{1'b1,   5,   3, NONE,    5,   3, RED};
    tbl[2] = '{1'b1, 160,   0, BLUE,  160,   0, BLACK};
    tbl[3] = '{1'b0,   0,   0, BLACK,   0,   1, BLACK};
    tbl[4] = '{1'b1, 159, 119, GREEN, 159, 119, GREEN};
    tbl[5] = '{1'b1,   0, 120, BLUE,    0, 120, BLACK};
    tbl[6] = '{1'b1, 255, 127, RED,   255, 127, BLACK};
    tbl[7] = '{1'b1,   1,   0, BLUE,    1,   0, BLUE};
    tbl[8] = '{1'b1,   4,   3, GREEN,   5,   3, RED};
    tbl[9] = '{1'b0,   0,   0, BLACK,   0,   0, BLACK};

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_rd_index", {28'b0, rd_index}, {28'b0, BLACK});
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_wr_ready", {31'b0, wr_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) do_write(tbl[i].wx, tbl[i].wy, tbl[i].wc);
      do_read_exp(tbl[i].rx, tbl[i].ry, tbl[i].exp);
    end

    // collision: same-cycle write and read of (0,0) returns the old value
    wr_en = 1'b1; wr_x = 8'd0; wr_y = 7'd0; wr_color = GREEN;
    do_read_exp(0, 0, BLACK);
    wr_en = 1'b0;
    do_read_exp(0, 0, GREEN);

    // random mix, expectations from the model
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_x     = 8'($urandom_range(0, 170));
      wr_y     = 7'($urandom_range(0, 125));
      wr_color = 4'($urandom_range(0, 15));
      rd_en    = 1'($urandom_range(0, 1));
      rd_x     = 8'($urandom_range(0, 170));
      rd_y     = 7'($urandom_range(0, 125));
      step();
    end
    idle_inputs();

    // streaming row 2
    for (int x = 0; x < WIDTH; x++) do_write(x, 2, 4'($urandom_range(0, 14)));
    step(); step();
    valid_cycles = 0;
    for (int x = 0; x < WIDTH; x++) begin
      rd_en = 1'b1; rd_x = 8'(x); rd_y = 7'd2;
      step();
    end
    rd_en = 1'b0;
    step(); step();
    chk("stream_valid_count", valid_cycles, WIDTH);

`ifdef COLOR_FB_CLEAR_EN
    do_write(7, 7, BLUE);
    busy_cycles = 0; done_cycles = 0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = (i < DEPTH - 10); wr_x = 8'(i % WIDTH); wr_y = 7'd0; wr_color = RED;
      clear_req = (i == 5000);
      step();
    end
    idle_inputs();
    chk("clear_busy_cycles", busy_cycles, DEPTH);
    chk("clear_done_pulses", done_cycles, 1);
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++)
        do_read_exp(x, y, BLACK);

    // reset 100 cycles into a clear
    do_write(150, 0, RED);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 99; i++) step();
    reset = 1'b1; rd_en = 1'b1; rd_x = 8'd1; rd_y = 7'd0;
    step();
    idle_inputs();
    chk("midclr_busy", {31'b0, busy}, 32'd0);
    chk("midclr_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("midclr_wr_ready", {31'b0, wr_ready}, 32'd1);
    do_read_exp(150, 0, RED);
    step(); step();
`else
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    do_write(9, 9, BLUE);
    do_read_exp(9, 9, BLUE);
    chk("noclr_busy", {31'b0, busy}, 32'd0);
`endif

    idle_inputs();
    step(); step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
